// File: rtl/imm_field_encoder_pkg.sv
// Shared definitions for the immediate field encoder and its sibling sign
// extender: select encodings, field widths, FSM state encoding and the
// signed-range helper used by the range checker.
package imm_field_encoder_pkg;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int JMP_W  = 26;

  // Signed widths checked by the range checker: raw imm16, and a 16-bit
  // word offset which spans 18 bits of byte offset.
  localparam int RANGE_W_IMM    = IMM_W;
  localparam int RANGE_W_BRANCH = IMM_W + 2;

  localparam logic [1:0] SSE_IMM16   = 2'b00;
  localparam logic [1:0] SSE_BRANCH  = 2'b01;
  localparam logic [1:0] SSE_JUMP    = 2'b10;
  localparam logic [1:0] SSE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_CHECK = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  // A value fits a signed field of 'width' bits when every bit from
  // width-1 up to the MSB equals the sign bit.
  function automatic logic fits_signed(input logic [DATA_W-1:0] v, input int width);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      if ((i >= width - 1) && (v[i] != v[DATA_W-1])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_field_encoder_range_check.sv
// imm_range_check: combinational signed-range test of a 32-bit difference.
// Ports:
//   diff  in  32  value to test
//   wide  in  1   0: 16-bit signed field, 1: 18-bit signed field
//   fits  out 1   diff is representable in the selected width
module imm_range_check
  import imm_field_encoder_pkg::*;
(
  input  logic [DATA_W-1:0] diff,
  input  logic              wide,
  output logic              fits
);

  logic fits_s;

  // Pick the checked width; the branch path needs two extra bits because
  // the field holds a word offset.
  always_comb begin
    fits_s = 1'b0;
    if (wide) begin
      fits_s = fits_signed(diff, RANGE_W_BRANCH);
    end else begin
      fits_s = fits_signed(diff, RANGE_W_IMM);
    end
  end

  assign fits = fits_s;

endmodule

// File: rtl/imm_field_encoder.sv
// imm_field_encoder: converts a 32-bit value (or absolute branch/jump target)
// back into the packed immediate field the sign extender would expand.
// Four-state FSM IDLE -> CALC -> CHECK -> HOLD with valid/ready on both sides.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake (ready only in IDLE)
//   sse                    00 imm16, 01 branch, 10 jump, 11 illegal
//   value, pc              operand / target and instruction address
//   out_valid/out_ready    result handshake (result held until accepted)
//   field                  encoded field, zero-padded above 16 bits for 00/01
//   err_range/align/sel    advisory error flags
module imm_field_encoder
  import imm_field_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sse,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [JMP_W-1:0]  field,
  output logic              err_range,
  output logic              err_align,
  output logic              err_sel
);

  state_t            state_r;
  logic [1:0]        sse_r;
  logic [DATA_W-1:0] value_r;
  logic [DATA_W-1:0] pc_r;
  logic [DATA_W-1:0] pc4_r;
  logic [DATA_W-1:0] diff_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [JMP_W-1:0]  field_r;
  logic              err_range_r;
  logic              err_align_r;
  logic              err_sel_r;

  logic              fits_s;
  logic              wide_s;
  logic [JMP_W-1:0]  field_s;
  logic              err_range_s;
  logic              err_align_s;
  logic              err_sel_s;

  assign wide_s = (sse_r == SSE_BRANCH);

  imm_range_check u_range (
    .diff (diff_r),
    .wide (wide_s),
    .fits (fits_s)
  );

  // Next result as seen in CHECK; fields keep the truncated bits even when
  // an error flag is raised.
  always_comb begin
    field_s     = {JMP_W{1'b0}};
    err_range_s = 1'b0;
    err_align_s = 1'b0;
    err_sel_s   = 1'b0;
    case (sse_r)
      SSE_IMM16: begin
        err_range_s = ~fits_s;
        field_s     = {{(JMP_W-IMM_W){1'b0}}, diff_r[IMM_W-1:0]};
      end
      SSE_BRANCH: begin
        err_align_s = (diff_r[1:0] != 2'b00);
        err_range_s = ~fits_s;
        field_s     = {{(JMP_W-IMM_W){1'b0}}, diff_r[IMM_W+1:2]};
      end
      SSE_JUMP: begin
        // Jump keeps pc4's top nibble, so the target must share it.
        err_align_s = (value_r[1:0] != 2'b00);
        err_range_s = (value_r[31:28] != pc4_r[31:28]);
        field_s     = value_r[JMP_W+1:2];
      end
      default: begin
        err_sel_s = 1'b1;
      end
    endcase
  end

  // Control FSM with operand capture and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      sse_r       <= 2'b00;
      value_r     <= {DATA_W{1'b0}};
      pc_r        <= {DATA_W{1'b0}};
      pc4_r       <= {DATA_W{1'b0}};
      diff_r      <= {DATA_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      field_r     <= {JMP_W{1'b0}};
      err_range_r <= 1'b0;
      err_align_r <= 1'b0;
      err_sel_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            sse_r      <= sse;
            value_r    <= value;
            pc_r       <= pc;
            in_ready_r <= 1'b0;
            state_r    <= ST_CALC;
          end
        end
        ST_CALC: begin
          pc4_r <= pc_r + 32'd4;
          if (sse_r == SSE_BRANCH) begin
            diff_r <= value_r - (pc_r + 32'd4);
          end else begin
            diff_r <= value_r;
          end
          state_r <= ST_CHECK;
        end
        ST_CHECK: begin
          field_r     <= field_s;
          err_range_r <= err_range_s;
          err_align_r <= err_align_s;
          err_sel_r   <= err_sel_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign field     = field_r;
  assign err_range = err_range_r;
  assign err_align = err_align_r;
  assign err_sel   = err_sel_r;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Self-checking bench for imm_field_encoder: directed cases, randomized
// requests against an arithmetic reference model, handshake hold and
// mid-operation reset.
module tb_imm_field_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sse;
  logic [31:0] value;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] field;
  logic        err_range;
  logic        err_align;
  logic        err_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] fld;
    logic        rng;
    logic        aln;
    logic        sel;
  } exp_t;

  imm_field_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sse       (sse),
    .value     (value),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .field     (field),
    .err_range (err_range),
    .err_align (err_align),
    .err_sel   (err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the encoding rules.
  function automatic exp_t model(input logic [1:0] s, input logic [31:0] v, input logic [31:0] p);
    exp_t e;
    logic [31:0] pc4;
    logic [31:0] d;
    longint sd;
    e.fld = 32'h0; e.rng = 1'b0; e.aln = 1'b0; e.sel = 1'b0;
    pc4 = p + 32'd4;
    case (s)
      2'd0: begin
        sd = longint'($signed(v));
        e.rng = (sd < -64'sd32768) || (sd > 64'sd32767);
        e.fld = v % 32'd65536;
      end
      2'd1: begin
        d  = v - pc4;
        sd = longint'($signed(d));
        e.aln = (d % 32'd4) != 32'd0;
        e.rng = (sd < -64'sd131072) || (sd > 64'sd131071);
        e.fld = (d / 32'd4) % 32'd65536;
      end
      2'd2: begin
        e.aln = (v % 32'd4) != 32'd0;
        e.rng = (v / 32'h10000000) != (pc4 / 32'h10000000);
        e.fld = (v / 32'd4) % 32'h04000000;
      end
      default: e.sel = 1'b1;
    endcase
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // One request; result held for 'hold' extra cycles before acceptance.
  task automatic run_req(input string tag, input logic [1:0] s, input logic [31:0] v,
                         input logic [31:0] p, input int hold);
    exp_t e;
    int lat;
    logic [25:0] f0;
    logic [31:0] rt;
    e = model(s, v, p);
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1; sse = s; value = v; pc = p;
    @(negedge clk);
    in_valid = 1'b0; sse = 2'($urandom); value = $urandom; pc = $urandom;
    check_eq({tag, "_busy_rdy"}, {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 32'd3);
    check_eq({tag, "_field"}, {6'd0, field}, e.fld);
    check_eq({tag, "_rng"}, {31'd0, err_range}, {31'd0, e.rng});
    check_eq({tag, "_aln"}, {31'd0, err_align}, {31'd0, e.aln});
    check_eq({tag, "_sel"}, {31'd0, err_sel}, {31'd0, e.sel});
    // Round trip through the extender when the encoding is clean.
    if (!e.rng && !e.aln && !e.sel) begin
      case (s)
        2'd0: begin
          rt = {{16{field[15]}}, field[15:0]};
          check_eq({tag, "_rt"}, rt, v);
        end
        2'd1: begin
          rt = {{14{field[15]}}, field[15:0], 2'b00};
          check_eq({tag, "_rt"}, rt, v - (p + 32'd4));
        end
        default: begin
          rt = p + 32'd4;
          rt = {rt[31:28], field, 2'b00};
          check_eq({tag, "_rt"}, rt, v);
        end
      endcase
    end
    f0 = field;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      check_eq({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, "_hold_fld"}, {6'd0, field}, {6'd0, f0});
      check_eq({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_done_vld"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_done_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Reset asserted 'stage' cycles after acceptance (0: CALC, 2: HOLD).
  task automatic reset_during(input string tag, input int stage);
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1; sse = 2'd0; value = 32'h1234; pc = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (stage) @(negedge clk);
    if (stage == 2) check_eq({tag, "_pre_vld"}, {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq({tag, "_rst_vld"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_rst_rdy"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_rst_fld"}, {6'd0, field}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq({tag, "_post_vld"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  s;
    logic [31:0] v;
    logic [31:0] p;
    rst_n = 1'b0; in_valid = 1'b0; sse = 2'd0; value = 32'd0; pc = 32'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_rdy", {31'd0, in_ready}, 32'd1);
    check_eq("reset_vld", {31'd0, out_valid}, 32'd0);
    check_eq("reset_fld", {6'd0, field}, 32'd0);
    check_eq("reset_err", {29'd0, err_range, err_align, err_sel}, 32'd0);
    rst_n = 1'b1;

    run_req("imm_neg_min", 2'd0, 32'hFFFF8000, 32'h0, 0);
    run_req("imm_pos_ovf", 2'd0, 32'h00008000, 32'h0, 0);
    run_req("br_fwd",      2'd1, 32'h00400010, 32'h00400000, 1);
    run_req("br_back",     2'd1, 32'h003FFFF4, 32'h00400000, 0);
    run_req("br_bad",      2'd1, 32'h00420006, 32'h00400000, 0);
    run_req("br_max",      2'd1, 32'h00420000, 32'h00400000, 0);
    run_req("j_nibble",    2'd2, 32'h10000000, 32'h0FFFFFFC, 0);
    run_req("j_far",       2'd2, 32'h10000000, 32'h00400000, 0);
    run_req("j_unal",      2'd2, 32'h00400002, 32'h00400000, 0);
    run_req("illegal",     2'd3, 32'hDEADBEEF, 32'h12345678, 0);
    run_req("hold5",       2'd1, 32'h00400100, 32'h00400000, 5);
    run_req("after_hold",  2'd0, 32'h00007FFF, 32'h0, 0);

    reset_during("rst_calc", 0);
    reset_during("rst_hold", 2);
    run_req("post_rst", 2'd0, 32'hFFFFFFFF, 32'h0, 0);

    for (int k = 0; k < 60; k++) begin
      s = 2'($urandom_range(0, 3));
      p = $urandom;
      case ($urandom_range(0, 2))
        0: v = $urandom;
        1: v = p + 32'd4 + ($urandom_range(0, 32'h7FFFF) - 32'h40000);
        default: v = {$urandom_range(0, 1) == 0 ? 16'h0000 : 16'hFFFF, 16'($urandom)};
      endcase
      run_req("rand", s, v, p, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
